// File: rtl/branch_pkg.sv
// Shared branch encodings and 2-bit saturating counter helpers used by the
// predictor and the branch unit.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [2:0] BR_JUMP = 3'b011;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;
  localparam logic [2:0] BR_BLTU = 3'b111;

  function automatic logic is_cond_branch(input logic [2:0] sel);
    return (sel != BR_NONE) && (sel != BR_JUMP);
  endfunction

  // Saturating step toward the resolved direction.
  function automatic bht_state_t bht_train(input bht_state_t s, input logic taken);
    if (taken) return (s == ST)  ? ST  : bht_state_t'(s + 2'd1);
    else       return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
  endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one train port.
module bht
  import branch_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_t       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_t table_q [ENTRIES];

  // No bypass: a same-cycle read sees the value before the train lands.
  assign rd_state = table_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is reset as flops because a reset must forget all learned state at once; a RAM macro could not do that.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= WNT;
    end else if (wr_en) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of block ordering.
      table_q[wr_idx] <= bht_train(table_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor plus Execute-stage mispredict detection,
// redirect generation, table training and a saturating mispredict counter.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] f_pc,
  input  logic                  f_is_cond,
  input  logic                  f_is_jal,
  input  logic [DATA_WIDTH-1:0] f_target,
  output logic                  f_pred_taken,
  output logic [DATA_WIDTH-1:0] f_next_pc,
  input  logic                  ex_valid,
  input  logic                  ex_stall,
  input  logic [2:0]            ex_branch_sel,
  input  logic                  ex_pc_sel,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_target,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush_fd,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  bht_state_t       f_state;
  logic             ex_active;
  logic             ex_is_branch;
  logic             train_en;
  logic             mispredict;
  logic [DATA_WIDTH-1:0] ex_pc_plus4;

  assign f_idx  = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (f_idx),
    .rd_state (f_state),
    .wr_en    (train_en),
    .wr_idx   (ex_idx),
    .wr_taken (ex_pc_sel)
  );

  // Fetch: jal is always predicted taken, jalr never is.
  assign f_pred_taken = f_is_jal | (f_is_cond & (f_state inside {WT, ST}));
  assign f_next_pc    = f_pred_taken ? f_target : f_pc + DATA_WIDTH'(4);

  // Reset gating keeps redirect quiet whatever Execute presents during reset.
  assign ex_active    = rst_n & ex_valid & ~ex_stall;
  assign ex_is_branch = (ex_branch_sel != BR_NONE);
  assign train_en     = ex_active & is_cond_branch(ex_branch_sel);
  assign mispredict   = ex_active & ex_is_branch & (ex_pc_sel != ex_pred_taken);

  assign ex_pc_plus4 = ex_pc + DATA_WIDTH'(4);
  assign redirect    = mispredict;
  assign flush_fd    = mispredict;
  assign redirect_pc = (mispredict & ex_pc_sel) ? ex_target : ex_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispredict_cnt <= '0;
    else if (mispredict && (mispredict_cnt != '1))
      mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random
// traffic, checked against an integer-counter reference model.
module tb_branch_predictor;

  localparam int DW  = 32;
  localparam int ENT = 16;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] f_pc = '0, f_target = '0, ex_pc = '0, ex_target = '0;
  logic          f_is_cond = 1'b0, f_is_jal = 1'b0;
  logic          ex_valid = 1'b0, ex_stall = 1'b0, ex_pc_sel = 1'b0, ex_pred_taken = 1'b0;
  logic [2:0]    ex_branch_sel = 3'b010;
  logic          f_pred_taken, redirect, flush_fd;
  logic [DW-1:0] f_next_pc, redirect_pc;
  logic [CW-1:0] mispredict_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(DW), .BHT_ENTRIES(ENT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_pc(f_pc), .f_is_cond(f_is_cond), .f_is_jal(f_is_jal), .f_target(f_target),
    .f_pred_taken(f_pred_taken), .f_next_pc(f_next_pc),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch_sel(ex_branch_sel),
    .ex_pc_sel(ex_pc_sel), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_fd(flush_fd), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    logic          pred;
    logic [DW-1:0] next_pc;
    logic          redir;
    logic [DW-1:0] rpc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain integers 0..3 per entry, taken when >= 2.
  int ctr [ENT];
  int mcount = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("f_pred_taken",   DW'(f_pred_taken),   DW'(e.pred));
      check("f_next_pc",      f_next_pc,           e.next_pc);
      check("redirect",       DW'(redirect),       DW'(e.redir));
      check("flush_fd",       DW'(flush_fd),       DW'(e.redir));
      check("redirect_pc",    redirect_pc,         e.rpc);
      check("mispredict_cnt", DW'(mispredict_cnt), DW'(e.cnt));
    end
  end

  task automatic drive(input logic rst, input logic [DW-1:0] fpc, input logic fcond,
                       input logic fjal, input logic [DW-1:0] ftgt, input logic ev,
                       input logic es, input logic [2:0] sel, input logic psel,
                       input logic ppred, input logic [DW-1:0] epc, input logic [DW-1:0] etgt);
    exp_t e;
    int   fi, ei;
    logic active, mis;
    @(posedge clk);
    #1;
    rst_n = rst; f_pc = fpc; f_is_cond = fcond; f_is_jal = fjal; f_target = ftgt;
    ex_valid = ev; ex_stall = es; ex_branch_sel = sel; ex_pc_sel = psel;
    ex_pred_taken = ppred; ex_pc = epc; ex_target = etgt;
    if (!rst) begin
      for (int i = 0; i < ENT; i++) ctr[i] = 1;
      mcount = 0;
    end
    fi = int'((fpc >> 2) % ENT);
    ei = int'((epc >> 2) % ENT);
    e.pred    = fjal || (fcond && ctr[fi] >= 2);
    e.next_pc = e.pred ? ftgt : fpc + 4;
    active    = rst && ev && !es;
    mis       = active && (sel != 3'b010) && (psel != ppred);
    e.redir   = mis;
    e.rpc     = (mis && psel) ? etgt : epc + 4;
    e.cnt     = CW'(mcount);
    sb.push_back(e);
    if (active && sel != 3'b010 && sel != 3'b011)
      ctr[ei] = psel ? ((ctr[ei] == 3) ? 3 : ctr[ei] + 1) : ((ctr[ei] == 0) ? 0 : ctr[ei] - 1);
    if (mis && mcount < CNT_MAX) mcount++;
  endtask

  task automatic idle(input logic [DW-1:0] fpc, input logic fcond);
    drive(1'b1, fpc, fcond, 1'b0, fpc + 32'h40, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [DW-1:0] rand_pc();
    return 32'h1000 + DW'($urandom_range(0, 31) << 2);
  endfunction

  initial begin
    int guard;
    logic [2:0] sel;
    logic [DW-1:0] epc;
    for (int i = 0; i < ENT; i++) ctr[i] = 1;

    // Reset state, then the untrained branch at 0x100.
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h100, 32'h140);
    idle(32'h100, 1'b1);
    @(negedge clk);
    check("t1_next_pc", f_next_pc, 32'h104);
    check("t1_cnt", DW'(mispredict_cnt), 32'd0);

    // Taken twice: first mispredicts, second (predicted taken) does not.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h100, 32'h140);
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 32'h100, 32'h140);
    idle(32'h100, 1'b1);
    @(negedge clk);
    check("t2_next_pc", f_next_pc, 32'h140);
    check("t2_cnt", DW'(mispredict_cnt), 32'd1);

    // Counter is ST; saturate once more, then one not-taken mispredict.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 32'h100, 32'h140);
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 32'h100, 32'h140);
    idle(32'h100, 1'b1);

    // jalr via jump select.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 32'h200, 32'h2000);
    idle(32'h200, 1'b1);

    // Mispredicting branch held three cycles, then released.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h380, 1'b1, (i < 3), 3'b100, 1'b1, 1'b0, 32'h300, 32'h380);
    idle(32'h300, 1'b1);

    // Same-index read and train: old prediction now, new one next cycle.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h140, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 32'h100, 32'h140);
    idle(32'h100, 1'b1);

    // Asynchronous reset mid-run with random Execute inputs present.
    drive(1'b0, 32'h300, 1'b1, 1'b0, 32'h380, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h300, 32'h380);
    idle(32'h300, 1'b1);

    // Random traffic on a small PC window so entries alias and saturate.
    for (int n = 0; n < 3000; n++) begin
      sel = 3'($urandom_range(0, 7));
      epc = rand_pc();
      drive(($urandom_range(0, 299) != 0), rand_pc(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), rand_pc(), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) == 0), sel,
            (sel == 3'b011) ? 1'b1 : 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), epc, rand_pc());
    end

    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drained", DW'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
